// File: rtl/bcd_to_clock_if.sv
// Time-set entry bus: serial BCD digit input from the keypad/UART side and
// the binary time load port toward the clock core.
interface bcd_to_clock_if;
    logic [3:0] i_digit;
    logic       i_digit_valid;
    logic       i_clear;
    logic       o_ready;
    logic [2:0] o_digit_idx;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic [5:0] o_seconds;
    logic       o_time_valid;
    logic       o_error;

    modport master (
        output i_digit, i_digit_valid, i_clear,
        input  o_ready, o_digit_idx, o_hours, o_minutes, o_seconds,
               o_time_valid, o_error
    );

    modport slave (
        input  i_digit, i_digit_valid, i_clear,
        output o_ready, o_digit_idx, o_hours, o_minutes, o_seconds,
               o_time_valid, o_error
    );
endinterface

// File: rtl/bcd_to_clock.sv
// Collects six range-checked BCD digits (HH MM SS, MSD first) and loads binary time.
// Optional idle timeout on partial entries: define BCD_TO_CLOCK_TIMEOUT_EN.
module bcd_to_clock #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    bcd_to_clock_if.slave  bus
);

    typedef enum logic {ENTRY, CONV} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] dig_q, dig_d;
    logic [4:0]      hrs_q, hrs_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic            tv_q, tv_d;
    logic            err_q, err_d;
    logic            reject;

    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
        return ({3'b0, tens} << 3) + ({3'b0, tens} << 1) + {3'b0, units};
    endfunction

    // Hours-units limit depends on the already stored hours-tens digit.
    always_comb begin
        reject = (bus.i_digit > 4'd9);
        case (idx_q)
            3'd0:    if (bus.i_digit > 4'd2) reject = 1'b1;
            3'd1:    if (dig_q[0] == 4'd2 && bus.i_digit > 4'd3) reject = 1'b1;
            3'd2,
            3'd4:    if (bus.i_digit > 4'd5) reject = 1'b1;
            default: ;
        endcase
    end

`ifdef BCD_TO_CLOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;

    assign cnt_nxt = cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        hrs_d   = hrs_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tv_d    = 1'b0;
        err_d   = 1'b0;
`ifdef BCD_TO_CLOCK_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ENTRY: begin
                if (bus.i_clear) begin
                    idx_d = '0;
                    dig_d = '0;
                end else if (bus.i_digit_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                        idx_d = '0;
                        dig_d = '0;
                    end else begin
                        dig_d[idx_q] = bus.i_digit;
                        if (idx_q == 3'd5) state_d = CONV;
                        else               idx_d = idx_q + 3'd1;
                    end
                end
`ifdef BCD_TO_CLOCK_TIMEOUT_EN
                else if (idx_q != 3'd0) begin
                    if (cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                        err_d = 1'b1;
                        idx_d = '0;
                        dig_d = '0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
`endif
            end
            CONV: begin
                hrs_d   = 5'(bcd2bin(dig_q[0], dig_q[1]));
                min_d   = 6'(bcd2bin(dig_q[2], dig_q[3]));
                sec_d   = 6'(bcd2bin(dig_q[4], dig_q[5]));
                tv_d    = 1'b1;
                idx_d   = '0;
                dig_d   = '0;
                state_d = ENTRY;
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ENTRY;
            idx_q   <= '0;
            dig_q   <= '0;
            hrs_q   <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            hrs_q   <= hrs_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tv_q    <= tv_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready      = (state_q == ENTRY);
    assign bus.o_digit_idx  = idx_q;
    assign bus.o_hours      = hrs_q;
    assign bus.o_minutes    = min_q;
    assign bus.o_seconds    = sec_q;
    assign bus.o_time_valid = tv_q;
    assign bus.o_error      = err_q;

endmodule
